// File: rtl/led_shift_ctrl.sv
// LED bank sequencer: steps a pattern once per rising edge of the slow
// divider clock, which is synchronised into clk_in and used only as data.
module led_shift_ctrl #(
    parameter int unsigned   N            = 8,
    parameter logic [N-1:0]  INIT_PATTERN = N'(8'b1000_0000)
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         slow_clk,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic         load,
    input  logic [N-1:0] load_pattern,
    output logic [N-1:0] led,
    output logic         step_tick,
    output logic         dir
);

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_ROR    = 2'b00;
    localparam logic [1:0] MODE_ROL    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    // Synchroniser chain and edge-detect qualification
    logic         s1_q, s2_q, s3_q;
    logic         v1_q, v2_q;
    logic         armed_q, armed_d;
    logic         tick_c;

    // Pattern, direction and step pulse state
    logic [N-1:0] led_q, led_d;
    dir_e         dir_q, dir_d;
    logic         step_q, step_d;

    // Three-flop synchroniser plus fill tracking. The reset zeros in s2 are
    // not real samples of slow_clk, so v2_q marks when s2 holds real data.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= slow_clk;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            v1_q    <= 1'b1;
            v2_q    <= v1_q;
            armed_q <= armed_d;
        end
    end

    // Arm only after a genuine low sample so a level held high across
    // reset release cannot masquerade as a rising edge.
    always_comb begin
        armed_d = armed_q | (v2_q & ~s2_q);
        tick_c  = s2_q & ~s3_q & armed_q;
    end

    // State register for pattern, bounce direction and step pulse
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            led_q  <= INIT_PATTERN;
            dir_q  <= RIGHT;
            step_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    // Next-state: load beats a step; a tick with en=0 is simply dropped
    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = 1'b0;

        if (load) begin
            led_d = load_pattern;
            dir_d = RIGHT;
        end else if (tick_c && en) begin
            case (mode)
                MODE_ROR: begin
                    led_d  = {led_q[0], led_q[N-1:1]};
                    step_d = 1'b1;
                end
                MODE_ROL: begin
                    led_d  = {led_q[N-2:0], led_q[N-1]};
                    step_d = 1'b1;
                end
                MODE_BOUNCE: begin
                    step_d = 1'b1;
                    // Reversal happens on the same tick that hits the end
                    case (dir_q)
                        RIGHT: begin
                            if (led_q[0]) begin
                                dir_d = LEFT;
                                led_d = led_q << 1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                        LEFT: begin
                            if (led_q[N-1]) begin
                                dir_d = RIGHT;
                                led_d = led_q >> 1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end
                        default: dir_d = RIGHT;
                    endcase
                end
                default: begin
                    // Hold mode: tick consumed, pattern frozen
                end
            endcase
        end
    end

    // Registered outputs
    assign led       = led_q;
    assign step_tick = step_q;
    assign dir       = (dir_q == LEFT);

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed bench for led_shift_ctrl (N=8).
module tb_led_shift_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       slow_clk;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_pattern;
    logic [7:0] led;
    logic       step_tick;
    logic       dir;

    int compared   = 0;
    int mismatched = 0;

    led_shift_ctrl #(.N(8), .INIT_PATTERN(8'h80)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .slow_clk     (slow_clk),
        .en           (en),
        .mode         (mode),
        .load         (load),
        .load_pattern (load_pattern),
        .led          (led),
        .step_tick    (step_tick),
        .dir          (dir)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One slow_clk rise driven at a negedge; the step lands two posedges
    // after the capture edge, so step_tick is still low one negedge earlier.
    task automatic do_step(input string tag, input logic [7:0] e_led,
                           input logic e_dir, input logic e_stp);
        slow_clk = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk({tag, "_pre_tick"}, 32'(step_tick), 32'd0);
        @(negedge clk_in);
        chk({tag, "_led"},  32'(led),       32'(e_led));
        chk({tag, "_dir"},  32'(dir),       32'(e_dir));
        chk({tag, "_tick"}, 32'(step_tick), 32'(e_stp));
        @(negedge clk_in);
        chk({tag, "_tick_one"}, 32'(step_tick), 32'd0);
        repeat (5) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (10) @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (6) @(negedge clk_in);
    endtask

    initial begin
        rst          = 1'b1;
        slow_clk     = 1'b0;
        en           = 1'b1;
        mode         = 2'b00;
        load         = 1'b0;
        load_pattern = 8'h00;

        // Reset values
        #1;
        chk("rst_led",  32'(led),       32'h80);
        chk("rst_dir",  32'(dir),       32'd0);
        chk("rst_tick", 32'(step_tick), 32'd0);
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (6) @(negedge clk_in);
        chk("idle_led", 32'(led), 32'h80);

        // Rotate right through a full revolution
        do_step("ror1", 8'h40, 1'b0, 1'b1);
        do_step("ror2", 8'h20, 1'b0, 1'b1);
        do_step("ror3", 8'h10, 1'b0, 1'b1);
        do_step("ror4", 8'h08, 1'b0, 1'b1);
        do_step("ror5", 8'h04, 1'b0, 1'b1);
        do_step("ror6", 8'h02, 1'b0, 1'b1);
        do_step("ror7", 8'h01, 1'b0, 1'b1);
        do_step("ror8", 8'h80, 1'b0, 1'b1);

        // Rotate left with MSB wrap, then hold
        mode = 2'b01;
        do_step("rol1", 8'h01, 1'b0, 1'b1);
        do_step("rol2", 8'h02, 1'b0, 1'b1);
        do_step("rol3", 8'h04, 1'b0, 1'b1);
        mode = 2'b11;
        do_step("hold1", 8'h04, 1'b0, 1'b0);
        do_step("hold2", 8'h04, 1'b0, 1'b0);

        // Bounce from reset pattern across both ends
        mode = 2'b10;
        do_reset();
        do_step("bnc_r1", 8'h40, 1'b0, 1'b1);
        do_step("bnc_r2", 8'h20, 1'b0, 1'b1);
        do_step("bnc_r3", 8'h10, 1'b0, 1'b1);
        do_step("bnc_r4", 8'h08, 1'b0, 1'b1);
        do_step("bnc_r5", 8'h04, 1'b0, 1'b1);
        do_step("bnc_r6", 8'h02, 1'b0, 1'b1);
        do_step("bnc_r7", 8'h01, 1'b0, 1'b1);
        do_step("bnc_rev0", 8'h02, 1'b1, 1'b1);
        do_step("bnc_l1", 8'h04, 1'b1, 1'b1);
        do_step("bnc_l2", 8'h08, 1'b1, 1'b1);
        do_step("bnc_l3", 8'h10, 1'b1, 1'b1);
        do_step("bnc_l4", 8'h20, 1'b1, 1'b1);
        do_step("bnc_l5", 8'h40, 1'b1, 1'b1);
        do_step("bnc_l6", 8'h80, 1'b1, 1'b1);
        do_step("bnc_rev7", 8'h40, 1'b0, 1'b1);

        // Both end bits set: reversal drops the opposite end bit
        load_pattern = 8'h81;
        load = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
        chk("ld81_led",  32'(led),       32'h81);
        chk("ld81_dir",  32'(dir),       32'd0);
        chk("ld81_tick", 32'(step_tick), 32'd0);
        repeat (3) @(negedge clk_in);
        do_step("bnc_81", 8'h02, 1'b1, 1'b1);

        // Load coincident with the tick: load wins, dir cleared
        mode = 2'b00;
        load_pattern = 8'hA5;
        slow_clk = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        load = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
        chk("ldtk_led",  32'(led),       32'hA5);
        chk("ldtk_tick", 32'(step_tick), 32'd0);
        chk("ldtk_dir",  32'(dir),       32'd0);
        repeat (5) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (10) @(negedge clk_in);
        chk("ldtk_nostep", 32'(led), 32'hA5);
        do_step("after_ld", 8'hD2, 1'b0, 1'b1);

        // slow_clk high across reset release gives no step
        slow_clk = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (12) @(negedge clk_in);
        chk("hi_rst_led",  32'(led),       32'h80);
        chk("hi_rst_tick", 32'(step_tick), 32'd0);
        slow_clk = 1'b0;
        repeat (6) @(negedge clk_in);
        chk("hi_rst_low_led", 32'(led), 32'h80);
        do_step("hi_rst_step", 8'h40, 1'b0, 1'b1);

        // en=0 drops the tick, and it is not replayed later
        en = 1'b0;
        do_step("en0", 8'h40, 1'b0, 1'b0);
        en = 1'b1;
        do_step("en1", 8'h20, 1'b0, 1'b1);

        // Async reset mid-bounce while moving left
        mode = 2'b10;
        load_pattern = 8'h01;
        load = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
        repeat (3) @(negedge clk_in);
        do_step("pre_rst", 8'h02, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_led", 32'(led), 32'h80);
        chk("async_dir", 32'(dir), 32'd0);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (4) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
